// File: rtl/pong_game_if.sv
// Bundled frame-rate control and status signals between the video timing /
// input side and the pong game sequencer.
interface pong_game_if;
    logic       frame_tick;
    logic       start;
    logic [8:0] paddle_l_pos_v;
    logic [8:0] paddle_r_pos_v;
    logic [9:0] ball_pos_h;
    logic [8:0] ball_pos_v;
    logic       ball_visible;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] state;
    logic       game_over;
    logic       winner_r;

    modport master (
        output frame_tick, start, paddle_l_pos_v, paddle_r_pos_v,
        input  ball_pos_h, ball_pos_v, ball_visible, score_l, score_r,
               state, game_over, winner_r
    );

    modport slave (
        input  frame_tick, start, paddle_l_pos_v, paddle_r_pos_v,
        output ball_pos_h, ball_pos_v, ball_visible, score_l, score_r,
               state, game_over, winner_r
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, wall/paddle contact, scoring and the
// idle/serve/rally/over phases, all advanced once per frame_tick.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | after reset; ball centred and hidden, waiting for start
//   ST_SERVE | ball centred and visible for SERVE_FRAMES ticks
//   ST_RALLY | ball moving; walls bounce, paddles return, edges score
//   ST_OVER  | a side reached WIN_SCORE; scores/winner held until start
module pong_game_ctrl #(
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int PADDLE_L_X    = 15,
    parameter int PADDLE_R_X    = 625,
    parameter int PADDLE_SIZE_V = 40,
    parameter int BALL_SIZE     = 4,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic        clk,
    input  logic        rst,
    pong_game_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RALLY = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]        H_CENTRE   = 10'(H_VISIBLE / 2);
    localparam logic [8:0]        V_CENTRE   = 9'(V_VISIBLE / 2);
    localparam logic [9:0]        H_MAX      = 10'(H_VISIBLE - 1);
    localparam logic [8:0]        V_TOP      = 9'(BALL_SIZE / 2);
    localparam logic [8:0]        V_BOT      = 9'(V_VISIBLE - 1 - BALL_SIZE / 2);
    localparam logic [9:0]        L_HIT_X    = 10'(PADDLE_L_X + 1);
    localparam logic [9:0]        R_HIT_X    = 10'(PADDLE_R_X - 1);
    localparam logic signed [9:0] PAD_HALF   = 10'(PADDLE_SIZE_V / 2);
    localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]        WIN        = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [9:0]       h_q, h_d;
    logic [8:0]       v_q, v_d;
    logic             dir_l_q, dir_l_d;
    logic             dir_u_q, dir_u_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [3:0]       score_l_q, score_l_d;
    logic [3:0]       score_r_q, score_r_d;
    logic             winner_r_q, winner_r_d;

    logic signed [9:0] diff_l, diff_r;
    logic              hit_l, hit_r;
    logic [3:0]        score_l_inc, score_r_inc;
    logic              point_l, point_r;

    // Paddle offsets are taken signed so a ball above the paddle cannot wrap
    // into a large positive distance.
    assign diff_l = $signed({1'b0, v_q}) - $signed({1'b0, bus.paddle_l_pos_v});
    assign diff_r = $signed({1'b0, v_q}) - $signed({1'b0, bus.paddle_r_pos_v});
    assign hit_l  = (diff_l <= PAD_HALF) && (diff_l >= -PAD_HALF);
    assign hit_r  = (diff_r <= PAD_HALF) && (diff_r >= -PAD_HALF);

    assign score_l_inc = (score_l_q >= WIN) ? WIN : score_l_q + 4'd1;
    assign score_r_inc = (score_r_q >= WIN) ? WIN : score_r_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        dir_l_d     = dir_l_q;
        dir_u_d     = dir_u_q;
        serve_cnt_d = serve_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_r_d  = winner_r_q;
        point_l     = 1'b0;
        point_r     = 1'b0;

        if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        state_d     = ST_SERVE;
                        h_d         = H_CENTRE;
                        v_d         = V_CENTRE;
                        dir_l_d     = 1'b0;
                        dir_u_d     = 1'b1;
                        serve_cnt_d = '0;
                        score_l_d   = 4'd0;
                        score_r_d   = 4'd0;
                        winner_r_d  = 1'b0;
                    end
                end

                ST_SERVE: begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_RALLY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end

                ST_RALLY: begin
                    if (dir_u_q) begin
                        if (v_q == V_TOP) begin
                            dir_u_d = 1'b0;
                            v_d     = v_q + 9'd1;
                        end else begin
                            v_d = v_q - 9'd1;
                        end
                    end else begin
                        if (v_q == V_BOT) begin
                            dir_u_d = 1'b1;
                            v_d     = v_q - 9'd1;
                        end else begin
                            v_d = v_q + 9'd1;
                        end
                    end

                    if (dir_l_q) begin
                        if (h_q == 10'd0) begin
                            point_r = 1'b1;
                        end else if (h_q == L_HIT_X && hit_l) begin
                            dir_l_d = 1'b0;
                            h_d     = h_q + 10'd1;
                        end else begin
                            h_d = h_q - 10'd1;
                        end
                    end else begin
                        if (h_q == H_MAX) begin
                            point_l = 1'b1;
                        end else if (h_q == R_HIT_X && hit_r) begin
                            dir_l_d = 1'b1;
                            h_d     = h_q - 10'd1;
                        end else begin
                            h_d = h_q + 10'd1;
                        end
                    end

                    // A point recentres the ball and overrides this tick's
                    // vertical step.
                    if (point_l || point_r) begin
                        h_d         = H_CENTRE;
                        v_d         = V_CENTRE;
                        dir_u_d     = 1'b1;
                        serve_cnt_d = '0;
                        if (point_l) begin
                            score_l_d = score_l_inc;
                            dir_l_d   = 1'b0;
                        end else begin
                            score_r_d = score_r_inc;
                            dir_l_d   = 1'b1;
                        end
                        if ((point_l && score_l_inc == WIN) ||
                            (point_r && score_r_inc == WIN)) begin
                            state_d    = ST_OVER;
                            winner_r_d = point_r;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            h_q         <= H_CENTRE;
            v_q         <= V_CENTRE;
            dir_l_q     <= 1'b0;
            dir_u_q     <= 1'b1;
            serve_cnt_q <= '0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            winner_r_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            dir_l_q     <= dir_l_d;
            dir_u_q     <= dir_u_d;
            serve_cnt_q <= serve_cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_r_q  <= winner_r_d;
        end
    end

    assign bus.ball_pos_h   = h_q;
    assign bus.ball_pos_v   = v_q;
    assign bus.ball_visible = (state_q == ST_SERVE) || (state_q == ST_RALLY);
    assign bus.score_l      = score_l_q;
    assign bus.score_r      = score_r_q;
    assign bus.state        = state_q;
    assign bus.game_over    = (state_q == ST_OVER);
    assign bus.winner_r     = winner_r_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (default rules and WIN_SCORE=1)
// share stimulus; expected snapshots are queued at drive time and popped after.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [8:0] pad_l = 9'd240;
    logic [8:0] pad_r0 = 9'd240;
    logic [8:0] pad_r1 = 9'd240;

    pong_game_if if0 ();
    pong_game_if if1 ();

    assign if0.frame_tick     = frame_tick;
    assign if0.start          = start;
    assign if0.paddle_l_pos_v = pad_l;
    assign if0.paddle_r_pos_v = pad_r0;
    assign if1.frame_tick     = frame_tick;
    assign if1.start          = start;
    assign if1.paddle_l_pos_v = pad_l;
    assign if1.paddle_r_pos_v = pad_r1;

    pong_game_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    pong_game_ctrl #(.WIN_SCORE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // {h[31:22], v[21:13], vis[12], score_l[11:8], score_r[7:4], state[3:2], game_over[1], winner_r[0]}
    logic [31:0] snap0, snap1;
    assign snap0 = {if0.ball_pos_h, if0.ball_pos_v, if0.ball_visible, if0.score_l,
                    if0.score_r, if0.state, if0.game_over, if0.winner_r};
    assign snap1 = {if1.ball_pos_h, if1.ball_pos_v, if1.ball_visible, if1.score_l,
                    if1.score_r, if1.state, if1.game_over, if1.winner_r};

    logic [31:0] sb_q[$];
    logic [31:0] e;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] pk(input int h, input int v, input logic vis,
                                       input int sl, input int sr, input int st,
                                       input logic go, input logic wr);
        return {10'(h), 9'(v), vis, 4'(sl), 4'(sr), 2'(st), go, wr};
    endfunction

    task automatic tick(input logic s);
        @(negedge clk);
        start = s;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'b0;
    endtask

    task automatic ticks(input int n, input logic s);
        for (int i = 0; i < n; i++) tick(s);
    endtask

    task automatic test_reset;
        // reset must win over a simultaneous tick with start
        sb_q.push_back(pk(320, 240, 0, 0, 0, 0, 0, 0));
        sb_q.push_back(pk(320, 240, 0, 0, 0, 0, 0, 0));
        rst = 1'b1; frame_tick = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0; start = 1'b0;
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL reset dut0: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL reset dut1: got %h expected %h", snap1, e); end

        sb_q.push_back(pk(320, 240, 0, 0, 0, 0, 0, 0));
        ticks(3, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL idle_no_start: got %h expected %h", snap0, e); end
    endtask

    task automatic test_serve;
        sb_q.push_back(pk(320, 240, 1, 0, 0, 1, 0, 0));
        sb_q.push_back(pk(320, 240, 1, 0, 0, 1, 0, 0));
        tick(1'b1);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL serve_enter dut0: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL serve_enter dut1: got %h expected %h", snap1, e); end

        sb_q.push_back(pk(320, 240, 1, 0, 0, 1, 0, 0));
        ticks(59, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL serve_59: got %h expected %h", snap0, e); end

        // outputs stay put between ticks
        sb_q.push_back(pk(320, 240, 1, 0, 0, 1, 0, 0));
        repeat (4) @(negedge clk);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL hold_no_tick: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(320, 240, 1, 0, 0, 2, 0, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL serve_to_rally: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(321, 239, 1, 0, 0, 2, 0, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL rally_first_step: got %h expected %h", snap0, e); end
    endtask

    task automatic test_wall;
        sb_q.push_back(pk(558, 2, 1, 0, 0, 2, 0, 0));
        ticks(237, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL top_wall_reach: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(559, 3, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(560, 4, 1, 0, 0, 2, 0, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL top_wall_bounce: got %h expected %h", snap0, e); end
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL moving_down: got %h expected %h", snap0, e); end
    endtask

    task automatic test_paddle;
        sb_q.push_back(pk(624, 68, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(624, 68, 1, 0, 0, 2, 0, 0));
        ticks(64, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL at_paddle dut0: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL at_paddle dut1: got %h expected %h", snap1, e); end

        // dut0 paddle exactly on the ball, dut1 paddle 172 lines away
        pad_r0 = 9'd68;
        sb_q.push_back(pk(623, 69, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(625, 69, 1, 0, 0, 2, 0, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL paddle_hit: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL paddle_miss: got %h expected %h", snap1, e); end

        sb_q.push_back(pk(609, 83, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(639, 83, 1, 0, 0, 2, 0, 0));
        ticks(14, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL return_left: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL right_edge: got %h expected %h", snap1, e); end

        sb_q.push_back(pk(608, 84, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(0, 0, 0, 1, 0, 3, 1, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL still_rally: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1[12:0] !== e[12:0]) begin n_err++; $display("FAIL win_to_over: got %h expected %h", snap1[12:0], e[12:0]); end
    endtask

    task automatic test_game_over;
        sb_q.push_back(pk(0, 0, 0, 1, 0, 3, 1, 0));
        ticks(3, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap1[12:0] !== e[12:0]) begin n_err++; $display("FAIL over_hold: got %h expected %h", snap1[12:0], e[12:0]); end

        // start restarts dut1 and is ignored by dut0 in rally
        sb_q.push_back(pk(604, 88, 1, 0, 0, 2, 0, 0));
        sb_q.push_back(pk(320, 240, 1, 0, 0, 1, 0, 0));
        tick(1'b1);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL rally_ignores_start: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL over_restart: got %h expected %h", snap1, e); end
    endtask

    task automatic test_reset_mid_rally;
        sb_q.push_back(pk(320, 240, 0, 0, 0, 0, 0, 0));
        sb_q.push_back(pk(320, 240, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL mid_rally_reset dut0: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1 !== e) begin n_err++; $display("FAIL mid_serve_reset dut1: got %h expected %h", snap1, e); end
    endtask

    task automatic test_point_serve;
        pad_r0 = 9'd240;
        pad_r1 = 9'd240;
        tick(1'b1);
        ticks(60, 1'b0);
        sb_q.push_back(pk(639, 83, 1, 0, 0, 2, 0, 0));
        ticks(319, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL miss_right_edge: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(320, 240, 1, 1, 0, 1, 0, 0));
        sb_q.push_back(pk(0, 0, 0, 1, 0, 3, 1, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL point_to_serve: got %h expected %h", snap0, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (snap1[12:0] !== e[12:0]) begin n_err++; $display("FAIL point_to_over: got %h expected %h", snap1[12:0], e[12:0]); end

        sb_q.push_back(pk(320, 240, 1, 1, 0, 1, 0, 0));
        tick(1'b1);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL serve_ignores_start: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(320, 240, 1, 1, 0, 1, 0, 0));
        ticks(58, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL reserve_last: got %h expected %h", snap0, e); end

        sb_q.push_back(pk(320, 240, 1, 1, 0, 2, 0, 0));
        tick(1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (snap0 !== e) begin n_err++; $display("FAIL reserve_to_rally: got %h expected %h", snap0, e); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_serve;
        test_wall;
        test_paddle;
        test_game_over;
        test_reset_mid_rally;
        test_point_serve;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
